// File: rtl/nlm_pkg.sv
// Shared types, default widths and the saturation helper for the NLM
// normalisation divider.
package nlm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NLM_DATA_WIDTH       = 16;
    localparam int NLM_PIX_SUM_WIDTH    = 32;
    localparam int NLM_WEIGHT_SUM_WIDTH = 32;

    // Clamp an unsigned quotient to the largest value representable in dw bits.
    function automatic logic [63:0] sat_u(input logic [63:0] q, input int unsigned dw);
        logic [63:0] max_v;
        max_v = (64'd1 << dw) - 64'd1;
        if (q > max_v) begin
            sat_u = max_v;
        end else begin
            sat_u = q;
        end
    endfunction

endpackage

// File: rtl/nlm_div_step.sv
// One restoring-division step: shift the next numerator bit into the partial
// remainder and subtract the divisor when it fits.
module nlm_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         num_bit_i,
    input  logic [W-1:0] den_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W+1:0] shifted_s;
    logic         fits_s;

    // Trial subtraction; the partial remainder never reaches the top bit, so
    // dropping it on the way out loses nothing.
    always_comb begin
        shifted_s = {rem_i, num_bit_i};
        fits_s    = (shifted_s >= {2'b00, den_i});
        q_o       = fits_s;
        if (fits_s) begin
            rem_o = (W+1)'(shifted_s - {2'b00, den_i});
        end else begin
            rem_o = (W+1)'(shifted_s);
        end
    end

endmodule

// File: rtl/nlm_norm_div.sv
// Terminal stage of the NLM PE chain: pix_o = sat(round(pix_sum / weight_sum)),
// computed by a bit-serial restoring divider behind valid/ready handshakes.
// A zero weight sum falls back to the unfiltered centre pixel.
module nlm_norm_div
    import nlm_pkg::*;
#(
    parameter int DATA_WIDTH       = NLM_DATA_WIDTH,
    parameter int PIX_SUM_WIDTH    = NLM_PIX_SUM_WIDTH,
    parameter int WEIGHT_SUM_WIDTH = NLM_WEIGHT_SUM_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [PIX_SUM_WIDTH-1:0]    pix_sum_i,
    input  logic [WEIGHT_SUM_WIDTH-1:0] weight_sum_i,
    input  logic [DATA_WIDTH-1:0]       center_pix_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DATA_WIDTH-1:0]       pix_o
);

    localparam int NUM_WIDTH = PIX_SUM_WIDTH + 1;
    localparam int CNT_W     = $clog2(NUM_WIDTH);

    state_t                      state_q, state_d;
    logic [NUM_WIDTH-1:0]        num_q, num_d;
    logic [WEIGHT_SUM_WIDTH-1:0] den_q, den_d;
    logic [WEIGHT_SUM_WIDTH:0]   rem_q, rem_d;
    logic [NUM_WIDTH-1:0]        quo_q, quo_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       pix_q, pix_d;
    logic                        valid_q, valid_d;
    logic                        ready_q, ready_d;

    logic [WEIGHT_SUM_WIDTH:0]   step_rem_s;
    logic                        step_q_s;

    nlm_div_step #(
        .W (WEIGHT_SUM_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .num_bit_i (num_q[cnt_q]),
        .den_i     (den_q),
        .rem_o     (step_rem_s),
        .q_o       (step_q_s)
    );

    // Next-state, datapath and handshake outputs; every target defaults to hold.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        valid_d = valid_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    // Adding half the divisor turns the truncating divide into round-half-up.
                    num_d   = NUM_WIDTH'(pix_sum_i) + NUM_WIDTH'(weight_sum_i >> 1);
                    den_d   = weight_sum_i;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(NUM_WIDTH - 1);
                    ready_d = 1'b0;
                    if (weight_sum_i == '0) begin
                        state_d = DONE;
                        pix_d   = center_pix_i;
                        valid_d = 1'b1;
                    end else begin
                        state_d = DIV;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            DIV: begin
                rem_d        = step_rem_s;
                quo_d[cnt_q] = step_q_s;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    pix_d   = DATA_WIDTH'(sat_u(64'(quo_d), DATA_WIDTH));
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Output held until the writer takes it; ready_o returns one cycle later.
                if (ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign pix_o   = pix_q;

endmodule

// File: tb/tb_nlm_norm_div.sv
// Self-checking bench for nlm_norm_div: directed cases plus randomized jobs
// compared against an arithmetic reference of round(pix/weight) with clamping.
module tb_nlm_norm_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] pix_sum_i = 32'd0;
    logic [31:0] weight_sum_i = 32'd0;
    logic [15:0] center_pix_i = 16'd0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [15:0] pix_o;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    nlm_norm_div dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pix_sum_i    (pix_sum_i),
        .weight_sum_i (weight_sum_i),
        .center_pix_i (center_pix_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .pix_o        (pix_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: round-half-up quotient clamped to 16 bits, centre pixel when weight is zero.
    function automatic logic [15:0] ref_pix(input logic [31:0] ps, input logic [31:0] ws,
                                            input logic [15:0] ctr);
        longint unsigned q;
        if (ws == 32'd0) return ctr;
        q = (longint'(ps) + longint'(ws / 32'd2)) / longint'(ws);
        if (q > 64'd65535) return 16'hFFFF;
        return q[15:0];
    endfunction

    // Latency counted in falling edges after the acceptance edge until valid_o is seen.
    // Valid appears after the acceptance edge itself for zero weight, 33 edges later otherwise.
    function automatic int ref_lat(input logic [31:0] ws);
        return (ws == 32'd0) ? 1 : 34;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) break;
        end
    endtask

    task automatic accept(input logic [31:0] ps, input logic [31:0] ws, input logic [15:0] ctr);
        wait_ready();
        pix_sum_i    = ps;
        weight_sum_i = ws;
        center_pix_i = ctr;
        valid_i      = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_o && n < 200);
    endtask

    task automatic run_job(input string tag, input logic [31:0] ps, input logic [31:0] ws,
                           input logic [15:0] ctr);
        int n;
        ready_i = 1'b1;
        accept(ps, ws, ctr);
        wait_valid(n);
        check({tag, "_lat"}, 64'(n), 64'(ref_lat(ws)));
        check({tag, "_pix"}, 64'(pix_o), 64'(ref_pix(ps, ws, ctr)));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(valid_o), 64'd0);
        check({tag, "_rdy"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int n;
        logic [31:0] ps, ws;
        logic [15:0] ctr;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_pix", 64'(pix_o), 64'd0);
        rst = 1'b0;

        // Directed cases
        run_job("basic", 32'd1000, 32'd10, 16'd7);
        run_job("round_up", 32'd1005, 32'd10, 16'd7);
        run_job("round_dn", 32'd1004, 32'd10, 16'd7);
        run_job("zero_w", 32'd1234, 32'd0, 16'h0ABC);
        run_job("sat_max", 32'hFFFF_FFFF, 32'd1, 16'd0);
        run_job("sat_2", 32'h0003_0000, 32'd2, 16'd0);
        check("exact_ref", 64'(ref_pix(32'd1000, 32'd10, 16'd7)), 64'd100);

        // Backpressure: hold output 10 cycles, stray valid_i must be ignored
        ready_i = 1'b0;
        accept(32'd777, 32'd7, 16'd1);
        wait_valid(n);
        check("bp_lat", 64'(n), 64'd34);
        pix_sum_i    = 32'd9999;
        weight_sum_i = 32'd3;
        valid_i      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(valid_o), 64'd1);
            check("bp_pix", 64'(pix_o), 64'd111);
            check("bp_ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_xfer_valid", 64'(valid_o), 64'd0);
        check("bp_xfer_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        check("bp_no_accept", 64'(ready_o), 64'd1);

        // Reset in the middle of a division
        accept(32'd1000, 32'd10, 16'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_ready", 64'(ready_o), 64'd1);
        check("mid_rst_pix", 64'(pix_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job("after_rst", 32'd50, 32'd5, 16'd0);

        // Randomized jobs across weight magnitudes
        for (int j = 0; j < 24; j++) begin
            ps  = $urandom;
            ctr = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ws = 32'd0;
                1: ws = 32'($urandom_range(1, 16));
                2: ws = 32'($urandom_range(1, 65535));
                default: begin
                    ws = $urandom;
                    if (ws == 32'd0) ws = 32'd1;
                end
            endcase
            if (j % 3 == 0) ps = ps >> $urandom_range(8, 20);
            run_job("rand", ps, ws, ctr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nlm_norm_div.md
Name: nlm_norm_div

Overview:
Terminal stage of the RAWDNS PE accumulation chain. It takes the final pix_sum and weight_sum produced by the last PE in a row and computes the denoised pixel as round(pix_sum / weight_sum), saturated to DATA_WIDTH bits. The division is an iterative restoring divider, one quotient bit per cycle. A valid/ready handshake sits on both sides, so the block can be backpressured by the output pixel writer.

Parameters:
DATA_WIDTH, 16, output pixel and center pixel width
PIX_SUM_WIDTH, 32, width of the incoming pixel-weighted sum
WEIGHT_SUM_WIDTH, 32, width of the incoming weight sum
NUM_WIDTH, PIX_SUM_WIDTH+1, derived (localparam); numerator width after the rounding bias is added

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  upstream sums and center pixel are valid
ready_o  output  1  block can accept a new job
pix_sum_i  input  PIX_SUM_WIDTH  accumulated sum of weight*pixel from the PE chain
weight_sum_i  input  WEIGHT_SUM_WIDTH  accumulated sum of weights from the PE chain
center_pix_i  input  DATA_WIDTH  unfiltered center pixel, used as a fallback
valid_o  output  1  pix_o is valid
ready_i  input  1  downstream accepts pix_o
pix_o  output  DATA_WIDTH  normalized, denoised pixel

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, ready_o=1, valid_o=0, pix_o=0, all internal registers=0.
- States:
  - IDLE: ready_o=1.
  - DIV: ready_o=0, valid_o=0.
  - DONE: ready_o=0, valid_o=1.
- Accept: on a clk edge with valid_i&&ready_o, latch the job:
  - num = pix_sum_i + (weight_sum_i>>1), NUM_WIDTH bits, no overflow possible.
  - den = weight_sum_i.
  - center = center_pix_i.
  - quotient and remainder cleared; bit counter = NUM_WIDTH-1.
  - If weight_sum_i==0, go directly to DONE with pix_o=center_pix_i at that same edge (valid_o high the cycle after acceptance). Otherwise go to DIV.
- DIV, one iteration per cycle, MSB first:
  - rem' = {rem, num[cnt]}; rem is WEIGHT_SUM_WIDTH+1 bits.
  - If rem' >= den: rem = rem'-den and q[cnt]=1; else rem = rem' and q[cnt]=0.
  - cnt decrements each cycle.
  - The iteration with cnt==0 is the last one. At that edge pix_o = (q > 2^DATA_WIDTH-1) ? all-ones : q[DATA_WIDTH-1:0], and state goes to DONE.
- Latency: acceptance edge t0; DIV occupies edges t1..tNUM_WIDTH; valid_o is high after edge tNUM_WIDTH (33 cycles at defaults). The zero-weight path has latency 1.
- DONE:
  - pix_o and valid_o are held stable while ready_i=0.
  - On an edge with ready_i=1, go to IDLE and clear valid_o. pix_o keeps its value, don't-care.
  - No new job is accepted in the same cycle as output completion; ready_o rises in the cycle after.
- Throughput: one job per NUM_WIDTH+2 cycles with ready_i tied high.
- valid_i while ready_o=0 is ignored. Upstream must hold its data per the handshake; the block does not buffer.
- Reset mid-DIV or mid-DONE: an immediate return to reset values. The in-flight job is discarded and no valid_o pulse is emitted.
- All arithmetic is unsigned. There is no signed interpretation of the sums.

Decomposition:
- Package nlm_pkg:
  - state enum {IDLE, DIV, DONE}
  - default widths DATA_WIDTH=16, PIX_SUM_WIDTH=32, WEIGHT_SUM_WIDTH=32
  - function sat_u(q, DATA_WIDTH) for clamping
- One natural sub-module: nlm_div_step, the combinational single-bit restoring step. Inputs rem, next numerator bit and den; outputs new rem and the q bit.
- The FSM, counter and handshake stay in nlm_norm_div.

Test Plan:
- pix_sum=1000, weight_sum=10, center=7, ready_i=1 -> pix_o=100, valid_o high exactly 33 cycles after acceptance, one-cycle pulse.
- Rounding: pix_sum=1005, weight_sum=10 -> pix_o=101. pix_sum=1004, weight_sum=10 -> pix_o=100.
- Zero weight: pix_sum=1234, weight_sum=0, center=0x0ABC -> pix_o=0x0ABC, valid_o one cycle after acceptance.
- Saturation: pix_sum=0xFFFFFFFF, weight_sum=1 -> pix_o=0xFFFF. Also pix_sum=0x00030000, weight_sum=2 -> 0xFFFF.
- Backpressure: ready_i=0 for 10 cycles after valid_o rises -> pix_o and valid_o stable, ready_o=0 throughout, and a new valid_i during the stall is ignored. When ready_i rises, one transfer occurs and ready_o=1 on the next cycle.
- Reset mid-DIV: assert rst at cycle 10 of a job -> valid_o=0 and ready_o=1 immediately. The next job (pix_sum=50, weight_sum=5) yields 10 with nominal latency.
